// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU slice.
//   - OP_W      : native opcode width of the encodings below
//   - OP_*      : opcode encodings (OP_W bits wide)
//   - aluState_t: FSM state encoding (IDLE, EXEC, SHIFT)
//   - isShift() : true for the iterative shift opcodes
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SLL = 6'b000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } aluState_t;

    function automatic logic isShift(input logic [OP_W-1:0] op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/alu_btn_edge.sv
// Rising-edge detector for one board button.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   btn   in  button level
//   pulse out registered one-cycle pulse, high the cycle after a 0->1 transition
// The history register resets to 1 so a button held through reset gives no edge.
module alu_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic btnHist;

    always_ff @(posedge clk) begin
        if (reset) begin
            btnHist <= 1'b1;
            pulse   <= 1'b0;
        end else begin
            btnHist <= btn;
            pulse   <= btn & ~btnHist;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU: captures A, B and the opcode from a shared switch bus on
// button edges, runs arith/logic ops in one EXEC cycle and shifts one bit per
// cycle, then presents a registered result and flags.
//   clk, reset         clock, synchronous active-high reset
//   i_data             shared switch bus
//   i_btn_a/b/op       button levels; rising edges latch A, B, opcode (+start)
//   o_result           result register, held until the next completion
//   o_carry            carry / borrow / last bit shifted out
//   o_overflow         signed overflow (ADD/SUB)
//   o_zero, o_negative derived from the new result
//   o_err              last op had an unknown opcode
//   o_busy             high whenever the FSM is not IDLE
//   o_valid            one-cycle pulse when result and flags update
//   dbgState           current FSM state, for debug/checkers
// Output protocol: o_valid is a pulse with no back-pressure; result and flags
// change only in the cycle o_valid is high and hold their value otherwise.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int OP_SIZE = OP_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] i_data,
    input  logic            i_btn_a,
    input  logic            i_btn_b,
    input  logic            i_btn_op,
    output logic [SIZE-1:0] o_result,
    output logic            o_carry,
    output logic            o_overflow,
    output logic            o_zero,
    output logic            o_negative,
    output logic            o_err,
    output logic            o_busy,
    output logic            o_valid,
    output logic [1:0]      dbgState
);

    localparam int CW = $clog2(SIZE + 1);
    localparam logic [SIZE-1:0] SIZE_V = SIZE'(SIZE);

    logic pulseA, pulseB, pulseOp;

    alu_btn_edge uEdgeA  (.clk(clk), .reset(reset), .btn(i_btn_a),  .pulse(pulseA));
    alu_btn_edge uEdgeB  (.clk(clk), .reset(reset), .btn(i_btn_b),  .pulse(pulseB));
    alu_btn_edge uEdgeOp (.clk(clk), .reset(reset), .btn(i_btn_op), .pulse(pulseOp));

    aluState_t         state;
    logic [SIZE-1:0]   aReg, bReg, workReg;
    logic [OP_SIZE-1:0] opReg;
    logic [CW-1:0]     countReg, shiftCount;
    logic [OP_W-1:0]   opKey;

    assign opKey    = OP_W'(opReg);
    assign o_busy   = (state != IDLE);
    assign dbgState = state;

    // Shift distance saturates at SIZE: anything beyond shifts everything out.
    assign shiftCount = (bReg > SIZE_V) ? CW'(SIZE) : CW'(bReg);

    // Extra top bit holds carry (ADD) or borrow (SUB).
    logic [SIZE:0] addSum, subDiff;
    assign addSum  = {1'b0, aReg} + {1'b0, bReg};
    assign subDiff = {1'b0, aReg} - {1'b0, bReg};

    logic [SIZE-1:0] aluResult;
    logic            aluCarry, aluOvf, aluErr;

    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        aluOvf    = 1'b0;
        aluErr    = 1'b0;
        case (opKey)
            OP_ADD: begin
                aluResult = addSum[SIZE-1:0];
                aluCarry  = addSum[SIZE];
                aluOvf    = (aReg[SIZE-1] == bReg[SIZE-1]) && (addSum[SIZE-1] != aReg[SIZE-1]);
            end
            OP_SUB: begin
                aluResult = subDiff[SIZE-1:0];
                aluCarry  = subDiff[SIZE];
                aluOvf    = (aReg[SIZE-1] != bReg[SIZE-1]) && (subDiff[SIZE-1] != aReg[SIZE-1]);
            end
            OP_AND:  aluResult = aReg & bReg;
            OP_OR:   aluResult = aReg | bReg;
            OP_XOR:  aluResult = aReg ^ bReg;
            OP_NOR:  aluResult = ~(aReg | bReg);
            default: aluErr    = 1'b1;
        endcase
    end

    // One-bit shift step of the working register.
    logic [SIZE-1:0] shiftNext;
    logic            shiftOut;

    always_comb begin
        shiftNext = {1'b0, workReg[SIZE-1:1]};
        shiftOut  = workReg[0];
        if (opKey == OP_SLL) begin
            shiftNext = {workReg[SIZE-2:0], 1'b0};
            shiftOut  = workReg[SIZE-1];
        end else if (opKey == OP_SRA) begin
            shiftNext = {workReg[SIZE-1], workReg[SIZE-1:1]};
        end
    end

    // Completion decode: which cycle finishes and what it publishes.
    logic            doneNow, doneCarry, doneOvf, doneErr;
    logic [SIZE-1:0] doneResult;

    always_comb begin
        doneNow    = 1'b0;
        doneResult = aluResult;
        doneCarry  = aluCarry;
        doneOvf    = aluOvf;
        doneErr    = aluErr;
        case (state)
            EXEC: begin
                if (!isShift(opKey)) begin
                    doneNow = 1'b1;
                end else if (shiftCount == '0) begin
                    // Zero-distance shift passes A through untouched.
                    doneNow    = 1'b1;
                    doneResult = aReg;
                    doneCarry  = 1'b0;
                    doneOvf    = 1'b0;
                    doneErr    = 1'b0;
                end
            end
            SHIFT: begin
                if (countReg == CW'(1)) begin
                    doneNow    = 1'b1;
                    doneResult = shiftNext;
                    doneCarry  = shiftOut;
                    doneOvf    = 1'b0;
                    doneErr    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            aReg       <= '0;
            bReg       <= '0;
            opReg      <= '0;
            workReg    <= '0;
            countReg   <= '0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
            o_negative <= 1'b0;
            o_err      <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Button edges only act here; while busy they are dropped.
                    if (pulseA) aReg <= i_data;
                    if (pulseB) bReg <= i_data;
                    if (pulseOp) begin
                        opReg <= i_data[OP_SIZE-1:0];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (doneNow) begin
                        state <= IDLE;
                    end else begin
                        workReg  <= aReg;
                        countReg <= shiftCount;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    workReg  <= shiftNext;
                    countReg <= countReg - CW'(1);
                    if (doneNow) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (doneNow) begin
                o_result   <= doneResult;
                o_carry    <= doneCarry;
                o_overflow <= doneOvf;
                o_zero     <= (doneResult == '0);
                o_negative <= doneResult[SIZE-1];
                o_err      <= doneErr;
                o_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (SIZE=8): drives button presses on the
// shared bus, predicts each completion with an independent model, and
// compares result, flags and latency when o_valid fires.
module tb_alu_seq_core;

    localparam int SIZE = 8;
    localparam int OPS  = 6;

    localparam logic [5:0] K_ADD = 6'b100000;
    localparam logic [5:0] K_SUB = 6'b100010;
    localparam logic [5:0] K_AND = 6'b100100;
    localparam logic [5:0] K_OR  = 6'b100101;
    localparam logic [5:0] K_XOR = 6'b100110;
    localparam logic [5:0] K_NOR = 6'b100111;
    localparam logic [5:0] K_SRL = 6'b000010;
    localparam logic [5:0] K_SRA = 6'b000011;
    localparam logic [5:0] K_SLL = 6'b000000;

    typedef struct packed {
        logic [31:0]     cycle;
        logic [SIZE-1:0] res;
        logic            c;
        logic            v;
        logic            z;
        logic            n;
        logic            e;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic            clk = 1'b0;
    logic            reset;
    logic [SIZE-1:0] i_data;
    logic            i_btn_a, i_btn_b, i_btn_op;
    logic [SIZE-1:0] o_result;
    logic            o_carry, o_overflow, o_zero, o_negative, o_err, o_busy, o_valid;
    logic [1:0]      dbgState;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int validCount = 0;
    int expectedValids = 0;
    logic [EW-1:0] expQ[$];

    alu_seq_core #(.SIZE(SIZE), .OP_SIZE(OPS)) dut (
        .clk(clk), .reset(reset), .i_data(i_data),
        .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
        .o_result(o_result), .o_carry(o_carry), .o_overflow(o_overflow),
        .o_zero(o_zero), .o_negative(o_negative), .o_err(o_err),
        .o_busy(o_busy), .o_valid(o_valid), .dbgState(dbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [5:0] op, input int edgeCyc);
        exp_t e;
        logic [8:0] s;
        logic [7:0] w;
        int sa, sb, r, cnt;
        e   = '0;
        cnt = 0;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        case (op)
            K_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[7:0];
                e.c = s[8];
                r = sa + sb;
                e.v = (r > 127) || (r < -128);
            end
            K_SUB: begin
                e.res = a - b;
                e.c = (a < b);
                r = sa - sb;
                e.v = (r > 127) || (r < -128);
            end
            K_AND: e.res = a & b;
            K_OR:  e.res = a | b;
            K_XOR: e.res = a ^ b;
            K_NOR: e.res = ~(a | b);
            K_SRL, K_SRA, K_SLL: begin
                cnt = (b > 8'd8) ? 8 : int'(b);
                w = a;
                for (int i = 0; i < cnt; i++) begin
                    if (op == K_SLL) begin
                        e.c = w[7];
                        w = w << 1;
                    end else begin
                        e.c = w[0];
                        w = (op == K_SRA) ? {w[7], w[7:1]} : (w >> 1);
                    end
                end
                e.res = w;
            end
            default: e.e = 1'b1;
        endcase
        e.z = (e.res == 8'h00);
        e.n = e.res[7];
        e.cycle = 32'(edgeCyc + 2 + cnt);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (o_valid) begin
            validCount++;
            if (expQ.size() == 0) begin
                checkVal("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkVal("latency",  32'(cyc),        e.cycle);
                checkVal("result",   32'(o_result),   32'(e.res));
                checkVal("carry",    32'(o_carry),    32'(e.c));
                checkVal("overflow", 32'(o_overflow), 32'(e.v));
                checkVal("zero",     32'(o_zero),     32'(e.z));
                checkVal("negative", 32'(o_negative), 32'(e.n));
                checkVal("err",      32'(o_err),      32'(e.e));
                checkVal("busy_at_valid", 32'(o_busy), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // mask = {op, b, a}; returns the clock edge at which the press is sampled.
    task automatic press(input logic [2:0] mask, input logic [7:0] data, output int edgeCyc);
        @(negedge clk);
        i_data = data;
        {i_btn_op, i_btn_b, i_btn_a} = mask;
        edgeCyc = cyc + 1;
        @(negedge clk);
        @(negedge clk);
        {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    endtask

    task automatic pushExp(input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input int edgeCyc);
        expQ.push_back(model(a, b, op, edgeCyc));
        expectedValids++;
    endtask

    task automatic waitValid();
        int t;
        t = 0;
        while (validCount < expectedValids && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (validCount < expectedValids) begin
            checkVal("valid_timeout", 32'(validCount), 32'(expectedValids));
            expQ.delete();
            expectedValids = validCount;
        end
    endtask

    // Launch an op with only the OP button; A/B come from earlier latches.
    task automatic launchOp(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int n;
        press(3'b100, {2'b00, op}, n);
        pushExp(a, b, op, n);
        checkVal("busy_after_launch", 32'(o_busy), 32'd1);
        waitValid();
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int n;
        press(3'b001, a, n);
        press(3'b010, b, n);
        launchOp(a, b, op);
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] opTable [9];

    initial begin
        int n, vBefore;
        logic [7:0] ra, rb;
        logic [5:0] rop;

        opTable = '{K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SRL, K_SRA, K_SLL};
        reset = 1'b1;
        i_data = '0;
        {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkVal("rst_result", 32'(o_result), 32'd0);
        checkVal("rst_flags", 32'({o_carry, o_overflow, o_zero, o_negative, o_err}), 32'd0);
        checkVal("rst_busy", 32'(o_busy), 32'd0);
        checkVal("rst_valid", 32'(o_valid), 32'd0);
        checkVal("rst_state", 32'(dbgState), 32'd0);

        // Directed cases
        runOp(8'h07, 8'h02, K_ADD);
        runOp(8'h80, 8'h80, K_ADD);
        runOp(8'h02, 8'h08, K_SUB);
        runOp(8'h7F, 8'h01, K_ADD);
        runOp(8'h80, 8'h01, K_SUB);
        runOp(8'h80, 8'h03, K_SRA);
        runOp(8'hFF, 8'h0A, K_SRL);
        runOp(8'h81, 8'h01, K_SLL);
        runOp(8'hA5, 8'h00, K_SLL);
        runOp(8'hC3, 8'h3C, K_NOR);
        runOp(8'h12, 8'h34, 6'b111111);
        runOp(8'hF0, 8'h3C, K_AND);

        // A, B and OP pressed together: all latch the same bus value (0x20 = ADD)
        press(3'b111, 8'h20, n);
        pushExp(8'h20, 8'h20, K_ADD, n);
        waitValid();

        // Presses during a shift are ignored
        press(3'b001, 8'hB5, n);
        press(3'b010, 8'h08, n);
        press(3'b100, {2'b00, K_SRL}, n);
        pushExp(8'hB5, 8'h08, K_SRL, n);
        @(negedge clk);
        press(3'b101, {2'b00, K_XOR}, n);
        waitValid();
        repeat (4) @(negedge clk);
        checkVal("no_extra_valid_shift", 32'(validCount), 32'(expectedValids));
        launchOp(8'hB5, 8'h08, K_ADD);

        // Buttons held high through reset produce no edge
        @(negedge clk);
        reset = 1'b1;
        vBefore = validCount;
        i_data = 8'h20;
        i_btn_a = 1'b1;
        i_btn_op = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkVal("held_reset_busy", 32'(o_busy), 32'd0);
        {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
        repeat (4) @(negedge clk);
        checkVal("held_reset_no_valid", 32'(validCount), 32'(vBefore));
        launchOp(8'h00, 8'h00, K_ADD);

        // Reset during SHIFT aborts without a valid pulse
        runOp(8'hFF, 8'h01, K_SUB);
        press(3'b001, 8'hFF, n);
        press(3'b010, 8'h08, n);
        press(3'b100, {2'b00, K_SRL}, n);
        repeat (2) @(negedge clk);
        checkVal("shift_busy", 32'(o_busy), 32'd1);
        vBefore = validCount;
        doReset(2);
        expQ.delete();
        expectedValids = validCount;
        checkVal("abort_result", 32'(o_result), 32'd0);
        checkVal("abort_flags", 32'({o_carry, o_overflow, o_zero, o_negative, o_err}), 32'd0);
        checkVal("abort_busy", 32'(o_busy), 32'd0);
        repeat (12) @(negedge clk);
        checkVal("abort_no_valid", 32'(validCount), 32'(vBefore));

        // Random operations
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) rop = 6'b010101;
            else rop = opTable[$urandom_range(0, 8)];
            if (rop == K_SRL || rop == K_SRA || rop == K_SLL) rb = 8'($urandom_range(0, 10));
            runOp(ra, rb, rop);
        end

        repeat (3) @(negedge clk);
        checkVal("queue_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
